// File: rtl/acs_pm_unit_if.sv
// Step interface between the branch-metric cells, the ACS/path-metric stage and traceback.
// The master drives branch metrics in. The slave returns survivor decisions and the best state.
interface acs_pm_if #(
  parameter int NUM_STATES = 64
);
  logic                      bm_valid;
  logic                      frame_start;
  logic [4*NUM_STATES-1:0]   bm_in;
  logic                      dec_valid;
  logic [NUM_STATES-1:0]     dec_bits;
  logic [5:0]                best_state;
  logic                      pm_norm;

  modport master (
    output bm_valid, frame_start, bm_in,
    input  dec_valid, dec_bits, best_state, pm_norm
  );

  modport slave (
    input  bm_valid, frame_start, bm_in,
    output dec_valid, dec_bits, best_state, pm_norm
  );
endinterface

// File: rtl/acs_pm_unit.sv
// Add-compare-select and path-metric stage of the K=7 rate-1/2 hard-decision Viterbi decoder.
// It performs one trellis step per cycle, with MSB normalisation and best-state search.
module acs_pm_unit #(
  parameter int NUM_STATES = 64,
  parameter int PM_W       = 8,
  parameter int INIT_PM    = 2**(PM_W-2)
) (
  input  logic        clk,
  input  logic        rst_n,
  acs_pm_if.slave     bus
);

  localparam int              SW     = $clog2(NUM_STATES);
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [PM_W-1:0]       r_pm [NUM_STATES];
  logic                  r_dec_valid;
  logic [NUM_STATES-1:0] r_dec_bits;
  logic [SW-1:0]         r_best_state;
  logic                  r_pm_norm;

  logic [PM_W-1:0]       w_old   [NUM_STATES];
  logic [PM_W-1:0]       w_new   [NUM_STATES];
  logic [PM_W-1:0]       w_store [NUM_STATES];
  logic [NUM_STATES-1:0] w_dec;
  logic [NUM_STATES-1:0] w_msb;
  logic                  w_norm;
  logic [SW-1:0]         w_best;

  logic [PM_W-1:0]       w_t_val [SW+1][NUM_STATES];
  logic [SW-1:0]         w_t_idx [SW+1][NUM_STATES];

  genvar g;
  generate
    for (g = 0; g < NUM_STATES; g++) begin : g_acs
      localparam int P0 = (2*g)   % NUM_STATES;
      localparam int P1 = (2*g+1) % NUM_STATES;

      logic [PM_W:0] w_cand0;
      logic [PM_W:0] w_cand1;
      logic [PM_W:0] w_sel;

      // frame_start substitutes the reset metric set for the registered one
      assign w_old[g] = bus.frame_start ? ((g == 0) ? '0 : INIT_V) : r_pm[g];

      assign w_cand0  = {1'b0, w_old[P0]} + (PM_W+1)'(bus.bm_in[4*g   +: 2]);
      assign w_cand1  = {1'b0, w_old[P1]} + (PM_W+1)'(bus.bm_in[4*g+2 +: 2]);
      assign w_dec[g] = (w_cand1 < w_cand0);
      assign w_sel    = w_dec[g] ? w_cand1 : w_cand0;
      assign w_new[g] = w_sel[PM_W] ? '1 : w_sel[PM_W-1:0];
      assign w_msb[g] = w_new[g][PM_W-1];

      assign w_store[g] = w_norm ? {1'b0, w_new[g][PM_W-2:0]} : w_new[g];
    end
  endgenerate

  assign w_norm = &w_msb;

  // Pairwise min tree; the left operand always carries the lower indices, so ties keep it
  always_comb begin
    for (int l = 0; l <= SW; l++) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        w_t_val[l][i] = '0;
        w_t_idx[l][i] = '0;
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      w_t_val[0][i] = w_store[i];
      w_t_idx[0][i] = SW'(i);
    end
    for (int l = 0; l < SW; l++) begin
      for (int i = 0; i < (NUM_STATES >> (l+1)); i++) begin
        if (w_t_val[l][2*i+1] < w_t_val[l][2*i]) begin
          w_t_val[l+1][i] = w_t_val[l][2*i+1];
          w_t_idx[l+1][i] = w_t_idx[l][2*i+1];
        end else begin
          w_t_val[l+1][i] = w_t_val[l][2*i];
          w_t_idx[l+1][i] = w_t_idx[l][2*i];
        end
      end
    end
    w_best = w_t_idx[SW][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : INIT_V;
      end
      r_dec_valid  <= 1'b0;
      r_dec_bits   <= '0;
      r_best_state <= '0;
      r_pm_norm    <= 1'b0;
    end else if (bus.bm_valid) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= w_store[s];
      end
      r_dec_valid  <= 1'b1;
      r_dec_bits   <= w_dec;
      r_best_state <= w_best;
      r_pm_norm    <= w_norm;
    end else begin
      if (bus.frame_start) begin
        for (int s = 0; s < NUM_STATES; s++) begin
          r_pm[s] <= w_old[s];
        end
      end
      r_dec_valid <= 1'b0;
      r_pm_norm   <= 1'b0;
    end
  end

  assign bus.dec_valid  = r_dec_valid;
  assign bus.dec_bits   = r_dec_bits;
  assign bus.best_state = 6'(r_best_state);
  assign bus.pm_norm    = r_pm_norm;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Bench for acs_pm_unit: directed trellis cases plus a random stream against an integer
// reference model of the add-compare-select rules, including asynchronous reset mid-stream.
module tb_acs_pm_unit;

  localparam int NS   = 64;
  localparam int INIT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  acs_pm_if #(.NUM_STATES(NS)) bus ();

  acs_pm_unit #(.NUM_STATES(NS), .PM_W(8), .INIT_PM(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          m_pm [NS];
  logic [63:0] m_bits;
  int          m_best;
  bit          m_valid;
  bit          m_norm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_pm[s] = (s == 0) ? 0 : INIT;
    m_bits  = '0;
    m_best  = 0;
    m_valid = 0;
    m_norm  = 0;
  endtask

  // One trellis step computed with plain integers; metrics saturate at 255, halve-offset at 128
  task automatic model_step(input bit bv, input bit fs, input logic [255:0] bm);
    int  old [NS];
    int  nw  [NS];
    int  c0, c1;
    bit  all_hi;
    for (int s = 0; s < NS; s++) old[s] = fs ? ((s == 0) ? 0 : INIT) : m_pm[s];
    if (bv) begin
      for (int s = 0; s < NS; s++) begin
        c0 = old[(2*s) % NS]   + int'(bm[4*s +: 2]);
        c1 = old[(2*s+1) % NS] + int'(bm[4*s+2 +: 2]);
        m_bits[s] = (c1 < c0);
        nw[s] = (c1 < c0) ? c1 : c0;
        if (nw[s] > 255) nw[s] = 255;
      end
      all_hi = 1;
      for (int s = 0; s < NS; s++) if (nw[s] < 128) all_hi = 0;
      for (int s = 0; s < NS; s++) m_pm[s] = all_hi ? nw[s] - 128 : nw[s];
      m_best = 0;
      for (int s = 1; s < NS; s++) if (m_pm[s] < m_pm[m_best]) m_best = s;
      m_valid = 1;
      m_norm  = all_hi;
    end else begin
      m_valid = 0;
      m_norm  = 0;
      if (fs) for (int s = 0; s < NS; s++) m_pm[s] = old[s];
    end
  endtask

  task automatic chk_model();
    chk("dec_valid", 64'(bus.dec_valid), 64'(m_valid));
    chk("dec_bits", bus.dec_bits, m_bits);
    chk("best_state", 64'(bus.best_state), 64'(m_best));
    chk("pm_norm", 64'(bus.pm_norm), 64'(m_norm));
  endtask

  task automatic drive_step(input bit bv, input bit fs, input logic [255:0] bm);
    @(negedge clk);
    bus.bm_valid    = bv;
    bus.frame_start = fs;
    bus.bm_in       = bm;
    @(posedge clk);
    model_step(bv, fs, bm);
    #1;
    chk_model();
  endtask

  function automatic logic [255:0] rand_bm();
    logic [255:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) begin
      v[4*s +: 2]   = 2'($urandom_range(0, 2));
      v[4*s+2 +: 2] = 2'($urandom_range(0, 2));
    end
    return v;
  endfunction

  task automatic chk_reset_pm(input string tag);
    for (int s = 0; s < NS; s++) chk(tag, 64'(dut.r_pm[s]), (s == 0) ? 64'd0 : 64'd64);
  endtask

  task automatic chk_zero_step_result(input string tag);
    chk({tag, "_valid"}, 64'(bus.dec_valid), 64'd1);
    chk({tag, "_bits"}, bus.dec_bits, 64'd0);
    chk({tag, "_best"}, 64'(bus.best_state), 64'd0);
    for (int s = 0; s < NS; s++)
      chk({tag, "_pm"}, 64'(dut.r_pm[s]), (s == 0 || s == 32) ? 64'd0 : 64'd64);
  endtask

  task automatic async_reset(input bit bv);
    @(negedge clk);
    bus.bm_valid    = bv;
    bus.frame_start = 1'b0;
    bus.bm_in       = rand_bm();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("rst_best", 64'(bus.best_state), 64'd0);
    chk("rst_norm", 64'(bus.pm_norm), 64'd0);
    chk("rst_bits", bus.dec_bits, 64'd0);
    chk_reset_pm("rst_pm");
    model_reset();
    @(negedge clk);
    bus.bm_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [255:0] all_zero;
    logic [255:0] tie_bm;
    logic [255:0] all_two;
    logic [63:0]  tie_bits;
    int           rst_at_a, rst_at_b;

    all_zero = '0;
    tie_bm   = {64{4'h2}};
    all_two  = {64{4'hA}};
    tie_bits = ~64'd0;
    tie_bits[0]  = 1'b0;
    tie_bits[32] = 1'b0;

    bus.bm_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.bm_in       = '0;
    model_reset();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("reset_best", 64'(bus.best_state), 64'd0);
    chk("reset_norm", 64'(bus.pm_norm), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_pm("reset_pm");

    // all-zero step from reset
    drive_step(1, 0, all_zero);
    chk_zero_step_result("zero");

    // tie-break against INIT
    async_reset(0);
    drive_step(1, 0, tie_bm);
    chk("tie_bits", bus.dec_bits, tie_bits);
    chk("tie_best", 64'(bus.best_state), 64'd0);
    for (int s = 0; s < NS; s++)
      chk("tie_pm", 64'(dut.r_pm[s]), (s == 0 || s == 32) ? 64'd2 : 64'd64);

    // normalisation after 64 steps of metric 2
    async_reset(0);
    for (int n = 1; n <= 64; n++) begin
      drive_step(1, 0, all_two);
      chk("norm_flag", 64'(bus.pm_norm), (n == 64) ? 64'd1 : 64'd0);
      if (n >= 6)
        for (int s = 0; s < NS; s++)
          chk("norm_pm", 64'(dut.r_pm[s]), (n == 64) ? 64'd0 : 64'(2*n));
    end
    chk("norm_best", 64'(bus.best_state), 64'd0);

    // frame_start alone, then an all-zero step
    for (int i = 0; i < 10; i++) drive_step(1, 0, rand_bm());
    drive_step(0, 1, all_zero);
    chk("fs_idle_valid", 64'(bus.dec_valid), 64'd0);
    drive_step(1, 0, all_zero);
    chk_zero_step_result("fs_idle");

    // frame_start together with bm_valid
    for (int i = 0; i < 10; i++) drive_step(1, 0, rand_bm());
    drive_step(1, 1, all_zero);
    chk_zero_step_result("fs_step");

    // random stream with two asynchronous resets
    rst_at_a = int'($urandom_range(1000, 4000));
    rst_at_b = int'($urandom_range(5000, 9000));
    for (int i = 0; i < 10000; i++) begin
      if (i == rst_at_a) async_reset(1);
      if (i == rst_at_b) async_reset(0);
      drive_step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), rand_bm());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
